controlador_acumulador: RTL and testbench
=========================================

CONTROLADOR_ACUMULADOR -- requirements
Module: controlador_acumulador

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable cycles that validates a button press or release (legal range 2..65535).
REQ-002 The block SHALL have parameter AUTO_PERIOD, default 8, giving the cycles between auto-mode increments (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_inc, input, 1 bit: raw, asynchronous increment button, active high.
REQ-006 The block SHALL have port btn_dec, input, 1 bit: raw, asynchronous decrement button, active high.
REQ-007 The block SHALL have port btn_clr, input, 1 bit: raw, asynchronous clear button, active high.
REQ-008 The block SHALL have port modo_auto, input, 1 bit: raw, asynchronous level enabling automatic sweep.
REQ-009 The block SHALL have port valor, output, 2 bits: registered accumulated state driven to the LED decoder.
REQ-010 The block SHALL have port ocupado, output, 1 bit: high whenever the FSM is not in REPOSO.

Function
REQ-011 Each of btn_inc, btn_dec, btn_clr and modo_auto SHALL pass through a 2-flop synchronizer; all logic uses only synchronized copies.
REQ-012 The FSM SHALL have states REPOSO, FILTRO, APLICAR and ESPERA_SUELTA, with ocupado = (state != REPOSO).
REQ-013 In REPOSO, if any synchronized button is high, the FSM SHALL latch one command by priority clr > inc > dec, clear the filter counter and enter FILTRO.
REQ-014 In FILTRO, if the latched button's synchronized level is low, the FSM SHALL return to REPOSO with no change to valor (glitch rejection).
REQ-015 In FILTRO, while the latched button is high, the filter counter SHALL increment; when it equals DEBOUNCE_CYCLES-1 with the button still high, the FSM SHALL enter APLICAR.
REQ-016 APLICAR SHALL last exactly one cycle, update valor and enter ESPERA_SUELTA: clr sets 0; inc sets (valor+1) mod 4; dec sets (valor-1) mod 4.
REQ-017 For a clean press, valor SHALL change on rising edge DEBOUNCE_CYCLES+4, counting the first edge that samples the raw button high as edge 1 (edge 8 for default parameters).
REQ-018 In ESPERA_SUELTA, the filter counter SHALL reset whenever any synchronized button is high and otherwise increment.
REQ-019 In ESPERA_SUELTA, the FSM SHALL return to REPOSO when all buttons have been low for DEBOUNCE_CYCLES consecutive cycles; one held press therefore yields exactly one update.
REQ-020 When synchronized modo_auto is 1 in REPOSO and no button is high, a prescaler SHALL count 0..AUTO_PERIOD-1; on reaching AUTO_PERIOD-1 it SHALL wrap to 0 and valor SHALL increment mod 4 in the same cycle.
REQ-021 The prescaler SHALL be cleared whenever modo_auto is 0 or the FSM leaves REPOSO, so button commands always take priority over auto increments.
REQ-022 In every cycle not covered by REQ-016 or REQ-020, valor SHALL hold its value.
REQ-023 Counters SHALL be sized to hold the larger of DEBOUNCE_CYCLES and AUTO_PERIOD without overflow.

Reset
REQ-024 On rst_n low, immediately and independent of clk, the block SHALL set: valor = 2'b00, ocupado = 0, FSM = REPOSO, synchronizers, latched command, filter counter and prescaler all 0.
REQ-025 Reset asserted mid-operation in any state SHALL abort the operation with no further valor update after release.
REQ-026 After rst_n rises, the block SHALL resume normal operation on the first rising clk edge.

Verification
REQ-027 Scenario: after reset, btn_inc held 20 cycles -> valor 0->1 exactly once, at edge 8; ocupado high from edge 3 until 4 low cycles after release.
REQ-028 Scenario: btn_inc high for 3 cycles only -> valor stays 0; ocupado pulses, then the FSM returns to REPOSO.
REQ-029 Scenario: four clean inc presses from 0 -> valor 1, 2, 3, 0; one dec press from 0 -> valor 3.
REQ-030 Scenario: valor=2, btn_clr and btn_inc rise together -> valor 0 (clr priority), single update.
REQ-031 Scenario: modo_auto=1, no buttons -> valor steps 0,1,2,3,0 every 8 cycles; an inc press mid-period restarts the prescaler after return to REPOSO.
REQ-032 Scenario: rst_n pulled low during FILTRO with valor=3 -> valor 0 and ocupado 0 asynchronously; no update after release.

Source files
------------

// File: rtl/controlador_acumulador.sv
// Debounced 2-bit up/down/clear accumulator with an optional automatic sweep.
// Raw buttons are synchronized, filtered by an FSM and applied once per press.
module controlador_acumulador #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    input  logic       modo_auto,
    output logic [1:0] valor,
    output logic       ocupado
);

    localparam int MAX_CNT = (DEBOUNCE_CYCLES > AUTO_PERIOD) ? DEBOUNCE_CYCLES : AUTO_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {REPOSO, FILTRO, APLICAR, ESPERA_SUELTA} estado_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_CLR, CMD_INC, CMD_DEC} cmd_t;

    // Bit order in the synchronizer: {modo_auto, clr, inc, dec}
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    estado_t       estado_q, estado_d;
    cmd_t          cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pre_q, pre_d;
    logic [1:0]    valor_q, valor_d;

    logic s_auto, s_clr, s_inc, s_dec, any_btn, cmd_btn;

    assign s_auto  = sync2_q[3];
    assign s_clr   = sync2_q[2];
    assign s_inc   = sync2_q[1];
    assign s_dec   = sync2_q[0];
    assign any_btn = s_clr | s_inc | s_dec;

    assign valor   = valor_q;
    assign ocupado = (estado_q != REPOSO);

    always_comb begin
        sync1_d = {modo_auto, btn_clr, btn_inc, btn_dec};
        sync2_d = sync1_q;
    end

    always_comb begin
        cmd_btn = 1'b0;
        case (cmd_q)
            CMD_CLR: cmd_btn = s_clr;
            CMD_INC: cmd_btn = s_inc;
            CMD_DEC: cmd_btn = s_dec;
            default: cmd_btn = 1'b0;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        pre_d    = '0;
        valor_d  = valor_q;
        case (estado_q)
            REPOSO: begin
                if (any_btn) begin
                    estado_d = FILTRO;
                    cnt_d    = '0;
                    cmd_d    = s_clr ? CMD_CLR : (s_inc ? CMD_INC : CMD_DEC);
                end else if (s_auto) begin
                    if (pre_q == AUTO_LAST) begin
                        pre_d   = '0;
                        valor_d = valor_q + 2'd1;
                    end else begin
                        pre_d = pre_q + CW'(1);
                    end
                end
            end
            FILTRO: begin
                if (!cmd_btn) begin
                    estado_d = REPOSO;
                end else if (cnt_q == DEB_LAST) begin
                    estado_d = APLICAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APLICAR: begin
                case (cmd_q)
                    CMD_CLR: valor_d = 2'd0;
                    CMD_INC: valor_d = valor_q + 2'd1;
                    CMD_DEC: valor_d = valor_q - 2'd1;
                    default: valor_d = valor_q;
                endcase
                cnt_d    = '0;
                estado_d = ESPERA_SUELTA;
            end
            ESPERA_SUELTA: begin
                // Any bounce restarts the release window
                if (any_btn) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            estado_q <= REPOSO;
            cmd_q    <= CMD_NONE;
            cnt_q    <= '0;
            pre_q    <= '0;
            valor_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            estado_q <= estado_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            valor_q  <= valor_d;
        end
    end

endmodule

// File: tb/tb_controlador_acumulador.sv
// Scoreboard bench for controlador_acumulador: stimulus tasks predict every valor
// update (value and clock edge), a negedge monitor compares each observed change.
module tb_controlador_acumulador;

    localparam int DEB = 4;
    localparam int AP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_clr = 1'b0, modo_auto = 1'b0;
    logic [1:0] valor;
    logic       ocupado;

    controlador_acumulador #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(AP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_clr   (btn_clr),
        .modo_auto (modo_auto),
        .valor     (valor),
        .ocupado   (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  val;
        int unsigned edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    logic [1:0]  mdl_val = 2'd0;
    logic [1:0]  prev_val = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every change of valor outside reset must match the head of the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_val = valor;
        end else if (valor !== prev_val) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: valor became %0d at edge %0d, expected no change", valor, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("update_value", int'(valor), int'(e.val));
                check("update_edge", int'(cyc), int'(e.edge_n));
            end
            prev_val = valor;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] apply_cmd(input logic c, input logic i, input logic [1:0] v);
        if (c) return 2'd0;
        if (i) return v + 2'd1;
        return v - 2'd1;
    endfunction

    task automatic gap();
        repeat (DEB + 4 + $urandom_range(0, 4)) @(negedge clk);
    endtask

    // Press held for n sampling edges; it registers only if it survives DEB+1 FSM looks
    task automatic press(input logic c, input logic i, input logic d, input int unsigned n);
        int unsigned t0;
        t0 = cyc;
        if (n >= DEB + 1) begin
            mdl_val = apply_cmd(c, i, mdl_val);
            exp_q.push_back('{mdl_val, t0 + DEB + 4});
        end
        btn_clr = c; btn_inc = i; btn_dec = d;
        repeat (n) @(negedge clk);
        btn_clr = 0; btn_inc = 0; btn_dec = 0;
        gap();
    endtask

    task automatic auto_run(input int unsigned k);
        int unsigned t0;
        t0 = cyc;
        for (int unsigned j = 1; j * AP <= k; j++) begin
            mdl_val = mdl_val + 2'd1;
            exp_q.push_back('{mdl_val, t0 + j * AP + 2});
        end
        modo_auto = 1;
        repeat (k) @(negedge clk);
        modo_auto = 0;
        gap();
    endtask

    // Auto sweep interrupted by an inc press p cycles in; auto restarts after idle
    task automatic auto_press(input int unsigned p, input int unsigned extra);
        int unsigned t0, n, r, k;
        t0 = cyc;
        n  = DEB + 2;
        r  = p + n + 2 + DEB;
        k  = r + extra;
        for (int unsigned j = 1; j * AP <= p; j++) begin
            mdl_val = mdl_val + 2'd1;
            exp_q.push_back('{mdl_val, t0 + j * AP + 2});
        end
        mdl_val = mdl_val + 2'd1;
        exp_q.push_back('{mdl_val, t0 + p + DEB + 4});
        for (int unsigned j = 1; r + j * AP <= k + 2; j++) begin
            mdl_val = mdl_val + 2'd1;
            exp_q.push_back('{mdl_val, t0 + r + j * AP});
        end
        modo_auto = 1;
        repeat (p) @(negedge clk);
        btn_inc = 1;
        repeat (n) @(negedge clk);
        btn_inc = 0;
        repeat (k - p - n) @(negedge clk);
        modo_auto = 0;
        gap();
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        check("reset_valor", int'(valor), 0);
        check("reset_ocupado", int'(ocupado), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Long inc hold: one update at edge 8, ocupado window checked
        begin
            int unsigned t0;
            t0 = cyc;
            mdl_val = 2'd1;
            exp_q.push_back('{2'd1, t0 + DEB + 4});
            btn_inc = 1;
            repeat (2) @(negedge clk);
            check("ocupado_edge2", int'(ocupado), 0);
            @(negedge clk);
            check("ocupado_edge3", int'(ocupado), 1);
            repeat (17) @(negedge clk);
            btn_inc = 0;
            check("ocupado_held", int'(ocupado), 1);
            repeat (DEB + 1) @(negedge clk);
            check("ocupado_release_wait", int'(ocupado), 1);
            @(negedge clk);
            check("ocupado_release_done", int'(ocupado), 0);
            gap();
        end

        // Short glitch: ocupado pulses, no update
        btn_inc = 1;
        repeat (3) @(negedge clk);
        btn_inc = 0;
        check("glitch_ocupado_high", int'(ocupado), 1);
        repeat (3) @(negedge clk);
        check("glitch_ocupado_low", int'(ocupado), 0);
        check("glitch_valor", int'(valor), int'(mdl_val));
        gap();

        repeat (4) press(0, 1, 0, DEB + 2);
        check("wrap_inc_valor", int'(valor), int'(mdl_val));
        while (mdl_val != 2'd0) press(1, 0, 0, DEB + 1);
        press(0, 0, 1, DEB + 1);
        check("dec_wrap_valor", int'(valor), 3);
        while (mdl_val != 2'd2) press(0, 1, 0, DEB + 3);
        press(1, 1, 0, DEB + 5);
        check("clr_priority", int'(valor), 0);

        auto_run(5 * AP);
        auto_press(12, 20);

        for (int it = 0; it < 40; it++) begin
            int unsigned sel;
            logic [2:0]  b;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                b = 3'($urandom_range(1, 7));
                press(b[2], b[1], b[0], $urandom_range(1, DEB + 4));
            end else if (sel < 8) begin
                auto_run($urandom_range(1, 4 * AP));
            end else begin
                auto_press($urandom_range(2, 2 * AP), $urandom_range(0, 3 * AP));
            end
        end

        // Reset during FILTRO with valor=3
        while (mdl_val != 2'd3) press(0, 1, 0, DEB + 2);
        btn_inc = 1;
        repeat (5) @(negedge clk);
        check("filtro_ocupado", int'(ocupado), 1);
        #2 rst_n = 0;
        #1;
        check("async_reset_valor", int'(valor), 0);
        check("async_reset_ocupado", int'(ocupado), 0);
        btn_inc = 0;
        mdl_val = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (DEB + 10) @(negedge clk);
        check("post_reset_valor", int'(valor), 0);
        check("post_reset_ocupado", int'(ocupado), 0);
        press(0, 1, 0, DEB + 1);

        repeat (20) @(negedge clk);
        check("pending_updates", exp_q.size(), 0);
        check("final_valor", int'(valor), int'(mdl_val));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
